mem_store_buffer: RTL and testbench

//  Write-side companion to the MEM load path. Accepts store requests from the EX/MEM

---
 rtl/mem_store_buffer_if.sv | 38 +++
 rtl/mem_store_buffer.sv | 183 ++++++++++++++++++
 tb/tb_mem_store_buffer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_store_buffer_if.sv
// Store-buffer handshake bundle: EX/MEM store request, MEM load probe and the
// drain port shared by the Dcache and the bus controller.
interface mem_store_buffer_if;
  logic        exmem_st_valid_i;
  logic [1:0]  exmem_mem_width_i;
  logic [31:0] exmem_mem_addr_i;
  logic [31:0] exmem_st_data_i;
  logic        fc_flush_mem_i;
  logic        st_ready_o;
  logic        st_misalign_o;

  logic        ld_valid_i;
  logic [31:0] ld_addr_i;
  logic        ld_conflict_o;

  logic        Dcache_req_o;
  logic        Dcache_ready_i;
  logic        bc_req_o;
  logic        bc_bus_ready_i;
  logic [31:0] wr_addr_o;
  logic [31:0] wr_wdata_o;
  logic [3:0]  wr_wstrb_o;
  logic        sb_empty_o;

  modport slave (
    input  exmem_st_valid_i, exmem_mem_width_i, exmem_mem_addr_i, exmem_st_data_i,
    input  fc_flush_mem_i, ld_valid_i, ld_addr_i, Dcache_ready_i, bc_bus_ready_i,
    output st_ready_o, st_misalign_o, ld_conflict_o, Dcache_req_o, bc_req_o,
    output wr_addr_o, wr_wdata_o, wr_wstrb_o, sb_empty_o
  );

  modport master (
    output exmem_st_valid_i, exmem_mem_width_i, exmem_mem_addr_i, exmem_st_data_i,
    output fc_flush_mem_i, ld_valid_i, ld_addr_i, Dcache_ready_i, bc_bus_ready_i,
    input  st_ready_o, st_misalign_o, ld_conflict_o, Dcache_req_o, bc_req_o,
    input  wr_addr_o, wr_wdata_o, wr_wstrb_o, sb_empty_o
  );
endinterface

// File: rtl/mem_store_buffer.sv
// In-order store buffer: aligns committed stores into byte-strobed words, queues them,
// and drains them one at a time to the Dcache or the bus controller (IO region).
module mem_store_buffer #(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] IO_BASE = 32'h4000_0000,
  parameter logic [31:0] IO_MASK = 32'hF000_0000
) (
  input  logic                clk,
  input  logic                rst,
  mem_store_buffer_if.slave   sb
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DC_REQ = 2'd1,
    BC_REQ = 2'd2
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] w, input logic [1:0] b);
    case (w)
      2'b10:   return b[0];
      2'b11:   return (b != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] align_strb(input logic [1:0] w, input logic [1:0] b);
    case (w)
      2'b01:   return 4'b0001 << b;
      2'b10:   return b[1] ? 4'b1100 : 4'b0011;
      2'b11:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] align_data(input logic [1:0] w, input logic [31:0] d);
    case (w)
      2'b01:   return {4{d[7:0]}};
      2'b10:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic in_io_region(input logic [31:0] a);
    return ((a & IO_MASK) == IO_BASE);
  endfunction

  logic [31:0]      ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [3:0]       ent_strb [DEPTH];
  logic [DEPTH-1:0] ent_vld;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  state_t           state;
  logic             dc_req;
  logic             bc_req;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_wdata;
  logic [3:0]       wr_wstrb;

  logic             misalign;
  logic             st_ready;
  logic             push;
  logic             pop;
  logic             ld_hit;

  // Request side: alignment checks and enqueue qualification
  assign misalign = is_misaligned(sb.exmem_mem_width_i, sb.exmem_mem_addr_i[1:0]);
  assign st_ready = (count != FULL_CNT);
  assign push     = sb.exmem_st_valid_i & st_ready & ~misalign & ~sb.fc_flush_mem_i &
                    (sb.exmem_mem_width_i != 2'b00);
  assign pop      = ((state == DC_REQ) & sb.Dcache_ready_i) |
                    ((state == BC_REQ) & sb.bc_bus_ready_i);

  assign sb.st_ready_o    = st_ready;
  assign sb.st_misalign_o = sb.exmem_st_valid_i & misalign;
  assign sb.sb_empty_o    = (count == '0);

  // Entry payload carries no reset; occupancy is tracked by ent_vld and count
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr] <= {sb.exmem_mem_addr_i[31:2], 2'b00};
      ent_data[wr_ptr] <= align_data(sb.exmem_mem_width_i, sb.exmem_st_data_i);
      ent_strb[wr_ptr] <= align_strb(sb.exmem_mem_width_i, sb.exmem_mem_addr_i[1:0]);
    end
  end

  // Occupancy control: pointers, count and per-entry valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (pop) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      if (push) begin
        ent_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Drain FSM: the head is latched into wr_* on leaving IDLE so it stays stable
  // for the whole request; the popped slot is only reused after the pop edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dc_req   <= 1'b0;
      bc_req   <= 1'b0;
      wr_addr  <= '0;
      wr_wdata <= '0;
      wr_wstrb <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            wr_addr  <= ent_addr[rd_ptr];
            wr_wdata <= ent_data[rd_ptr];
            wr_wstrb <= ent_strb[rd_ptr];
            if (in_io_region(ent_addr[rd_ptr])) begin
              state  <= BC_REQ;
              bc_req <= 1'b1;
            end else begin
              state  <= DC_REQ;
              dc_req <= 1'b1;
            end
          end
        end
        DC_REQ: begin
          if (sb.Dcache_ready_i) begin
            state  <= IDLE;
            dc_req <= 1'b0;
          end
        end
        BC_REQ: begin
          if (sb.bc_bus_ready_i) begin
            state  <= IDLE;
            bc_req <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          dc_req <= 1'b0;
          bc_req <= 1'b0;
        end
      endcase
    end
  end

  assign sb.Dcache_req_o = dc_req;
  assign sb.bc_req_o     = bc_req;
  assign sb.wr_addr_o    = wr_addr;
  assign sb.wr_wdata_o   = wr_wdata;
  assign sb.wr_wstrb_o   = wr_wstrb;

  // Load alias check on word address; an entry popping this cycle is still valid
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (((ent_addr[i] ^ sb.ld_addr_i) & 32'hFFFF_FFFC) == 32'h0))
        ld_hit = 1'b1;
    end
  end

  assign sb.ld_conflict_o = sb.ld_valid_i & ld_hit;

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer: alignment, full handling, routing order,
// load aliasing, reset and flush behaviour.
module tb_mem_store_buffer;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mem_store_buffer_if sbif ();

  mem_store_buffer #(
    .DEPTH   (4),
    .IO_BASE (32'h4000_0000),
    .IO_MASK (32'hF000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "simulation timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sbif.exmem_st_valid_i  = 1'b0;
    sbif.exmem_mem_width_i = 2'b00;
    sbif.exmem_mem_addr_i  = 32'h0;
    sbif.exmem_st_data_i   = 32'h0;
    sbif.fc_flush_mem_i    = 1'b0;
    sbif.ld_valid_i        = 1'b0;
    sbif.ld_addr_i         = 32'h0;
    sbif.Dcache_ready_i    = 1'b0;
    sbif.bc_bus_ready_i    = 1'b0;
  endtask

  task automatic drive_store(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    sbif.exmem_st_valid_i  = 1'b1;
    sbif.exmem_mem_width_i = w;
    sbif.exmem_mem_addr_i  = a;
    sbif.exmem_st_data_i   = d;
  endtask

  task automatic stop_store();
    sbif.exmem_st_valid_i  = 1'b0;
    sbif.exmem_mem_width_i = 2'b00;
  endtask

  // Wait (bounded) for a request, check target and head address, then accept it
  task automatic drain(input logic [31:0] exp_addr, input logic exp_bc, input string tag);
    int n;
    n = 0;
    while (!(sbif.Dcache_req_o || sbif.bc_req_o) && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, {30'h0, sbif.bc_req_o, sbif.Dcache_req_o}, exp_bc ? 32'h2 : 32'h1);
    chk({tag, "_addr"}, sbif.wr_addr_o, exp_addr);
    if (exp_bc) sbif.bc_bus_ready_i = 1'b1;
    else        sbif.Dcache_ready_i = 1'b1;
    tick();
    sbif.bc_bus_ready_i = 1'b0;
    sbif.Dcache_ready_i = 1'b0;
  endtask

  initial begin
    int n;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_dc_req", {31'h0, sbif.Dcache_req_o}, 32'h0);
    chk("rst_bc_req", {31'h0, sbif.bc_req_o}, 32'h0);
    chk("rst_empty", {31'h0, sbif.sb_empty_o}, 32'h1);
    chk("rst_ready", {31'h0, sbif.st_ready_o}, 32'h1);
    chk("rst_wr_addr", sbif.wr_addr_o, 32'h0);
    chk("rst_wr_wdata", sbif.wr_wdata_o, 32'h0);
    chk("rst_wr_wstrb", {28'h0, sbif.wr_wstrb_o}, 32'h0);
    rst = 1'b0;
    tick();

    // T1: byte store at 0x105 -> word 0x104, lane 1
    drive_store(2'b01, 32'h0000_0105, 32'h0000_00AB);
    #1;
    chk("t1_misalign", {31'h0, sbif.st_misalign_o}, 32'h0);
    tick();
    stop_store();
    chk("t1_empty_after_enq", {31'h0, sbif.sb_empty_o}, 32'h0);
    chk("t1_req_cycle1", {31'h0, sbif.Dcache_req_o}, 32'h0);
    tick();
    chk("t1_req_cycle2", {31'h0, sbif.Dcache_req_o}, 32'h1);
    chk("t1_bc_req", {31'h0, sbif.bc_req_o}, 32'h0);
    chk("t1_addr", sbif.wr_addr_o, 32'h0000_0104);
    chk("t1_wdata", sbif.wr_wdata_o, 32'hABAB_ABAB);
    chk("t1_wstrb", {28'h0, sbif.wr_wstrb_o}, 32'h2);
    sbif.bc_bus_ready_i = 1'b1;
    tick();
    sbif.bc_bus_ready_i = 1'b0;
    chk("t1_bc_ready_ignored", {31'h0, sbif.Dcache_req_o}, 32'h1);
    chk("t1_still_pending", {31'h0, sbif.sb_empty_o}, 32'h0);
    chk("t1_addr_stable", sbif.wr_addr_o, 32'h0000_0104);
    sbif.Dcache_ready_i = 1'b1;
    tick();
    sbif.Dcache_ready_i = 1'b0;
    chk("t1_req_drop", {31'h0, sbif.Dcache_req_o}, 32'h0);
    chk("t1_empty_after_pop", {31'h0, sbif.sb_empty_o}, 32'h1);

    // T2: half store at 0x102, then misaligned word store rejected
    drive_store(2'b10, 32'h0000_0102, 32'h0000_1234);
    tick();
    stop_store();
    tick();
    chk("t2_req", {31'h0, sbif.Dcache_req_o}, 32'h1);
    chk("t2_addr", sbif.wr_addr_o, 32'h0000_0100);
    chk("t2_wdata", sbif.wr_wdata_o, 32'h1234_1234);
    chk("t2_wstrb", {28'h0, sbif.wr_wstrb_o}, 32'hC);
    drive_store(2'b11, 32'h0000_0101, 32'hDEAD_BEEF);
    sbif.Dcache_ready_i = 1'b1;
    #1;
    chk("t2_sw_misalign", {31'h0, sbif.st_misalign_o}, 32'h1);
    tick();
    sbif.Dcache_ready_i = 1'b0;
    chk("t2_misalign_not_enq", {31'h0, sbif.sb_empty_o}, 32'h1);
    drive_store(2'b10, 32'h0000_0103, 32'h0);
    sbif.fc_flush_mem_i = 1'b1;
    #1;
    chk("t2_misalign_with_flush", {31'h0, sbif.st_misalign_o}, 32'h1);
    sbif.fc_flush_mem_i = 1'b0;
    sbif.exmem_mem_width_i = 2'b00;
    sbif.exmem_mem_addr_i  = 32'h0000_0101;
    #1;
    chk("t2_none_no_misalign", {31'h0, sbif.st_misalign_o}, 32'h0);
    tick();
    stop_store();
    chk("t2_none_no_enq", {31'h0, sbif.sb_empty_o}, 32'h1);

    // T3: five back-to-back words with the Dcache stalled
    for (int i = 0; i < 4; i++) begin
      drive_store(2'b11, 32'h0000_0300 + 32'(4 * i), 32'h0000_1000 + 32'(i));
      #1;
      chk($sformatf("t3_ready_%0d", i), {31'h0, sbif.st_ready_o}, 32'h1);
      tick();
    end
    chk("t3_full", {31'h0, sbif.st_ready_o}, 32'h0);
    drive_store(2'b11, 32'h0000_0310, 32'h0000_1004);
    tick();
    chk("t3_held", {31'h0, sbif.st_ready_o}, 32'h0);
    chk("t3_head_addr", sbif.wr_addr_o, 32'h0000_0300);
    chk("t3_head_data", sbif.wr_wdata_o, 32'h0000_1000);
    sbif.Dcache_ready_i = 1'b1;
    tick();
    sbif.Dcache_ready_i = 1'b0;
    chk("t3_no_enq_on_pop", {31'h0, sbif.st_ready_o}, 32'h1);
    tick();
    stop_store();
    chk("t3_fifth_accepted", {31'h0, sbif.st_ready_o}, 32'h0);
    drain(32'h0000_0304, 1'b0, "t3_d1");
    drain(32'h0000_0308, 1'b0, "t3_d2");
    drain(32'h0000_030C, 1'b0, "t3_d3");
    drain(32'h0000_0310, 1'b0, "t3_d4");
    chk("t3_drained", {31'h0, sbif.sb_empty_o}, 32'h1);

    // T4: IO store ahead of a cached store keeps strict order
    drive_store(2'b11, 32'h4000_0010, 32'h1);
    tick();
    drive_store(2'b11, 32'h0000_0020, 32'h2);
    tick();
    stop_store();
    chk("t4_bc_first", {31'h0, sbif.bc_req_o}, 32'h1);
    chk("t4_dc_not_first", {31'h0, sbif.Dcache_req_o}, 32'h0);
    chk("t4_io_addr", sbif.wr_addr_o, 32'h4000_0010);
    sbif.Dcache_ready_i = 1'b1;
    tick();
    tick();
    sbif.Dcache_ready_i = 1'b0;
    chk("t4_dc_ready_ignored", {31'h0, sbif.bc_req_o}, 32'h1);
    chk("t4_not_popped", {31'h0, sbif.sb_empty_o}, 32'h0);
    drain(32'h4000_0010, 1'b1, "t4_d1");
    chk("t4_no_dc_yet", {31'h0, sbif.Dcache_req_o}, 32'h0);
    drain(32'h0000_0020, 1'b0, "t4_d2");
    chk("t4_drained", {31'h0, sbif.sb_empty_o}, 32'h1);

    // T5: load aliasing against a pending word store
    drive_store(2'b11, 32'h0000_0200, 32'h55);
    tick();
    stop_store();
    sbif.ld_valid_i = 1'b1;
    sbif.ld_addr_i  = 32'h0000_0202;
    #1;
    chk("t5_conflict_same_word", {31'h0, sbif.ld_conflict_o}, 32'h1);
    sbif.ld_addr_i = 32'h0000_0204;
    #1;
    chk("t5_no_conflict_next_word", {31'h0, sbif.ld_conflict_o}, 32'h0);
    sbif.ld_valid_i = 1'b0;
    sbif.ld_addr_i  = 32'h0000_0200;
    #1;
    chk("t5_no_conflict_no_load", {31'h0, sbif.ld_conflict_o}, 32'h0);
    sbif.ld_valid_i = 1'b1;
    sbif.ld_addr_i  = 32'h0000_0203;
    n = 0;
    while (!sbif.Dcache_req_o && n < 10) begin
      tick();
      n++;
    end
    chk("t5_req", {31'h0, sbif.Dcache_req_o}, 32'h1);
    sbif.Dcache_ready_i = 1'b1;
    #1;
    chk("t5_conflict_pop_cycle", {31'h0, sbif.ld_conflict_o}, 32'h1);
    tick();
    sbif.Dcache_ready_i = 1'b0;
    #1;
    chk("t5_conflict_cleared", {31'h0, sbif.ld_conflict_o}, 32'h0);
    chk("t5_empty", {31'h0, sbif.sb_empty_o}, 32'h1);
    sbif.ld_valid_i = 1'b0;

    // T6: reset drops pending entries; flush blocks enqueue only
    drive_store(2'b11, 32'h0000_0500, 32'h5);
    tick();
    drive_store(2'b11, 32'h0000_0504, 32'h6);
    tick();
    drive_store(2'b11, 32'h0000_0508, 32'h7);
    tick();
    stop_store();
    chk("t6_req_active", {31'h0, sbif.Dcache_req_o}, 32'h1);
    chk("t6_pending", {31'h0, sbif.sb_empty_o}, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_req", {31'h0, sbif.Dcache_req_o}, 32'h0);
    chk("t6_rst_empty", {31'h0, sbif.sb_empty_o}, 32'h1);
    chk("t6_rst_ready", {31'h0, sbif.st_ready_o}, 32'h1);
    chk("t6_rst_wr_addr", sbif.wr_addr_o, 32'h0);
    tick();
    chk("t6_stays_idle", {31'h0, sbif.Dcache_req_o}, 32'h0);
    drive_store(2'b11, 32'h0000_0600, 32'h8);
    sbif.fc_flush_mem_i = 1'b1;
    tick();
    stop_store();
    sbif.fc_flush_mem_i = 1'b0;
    chk("t6_flush_no_enq", {31'h0, sbif.sb_empty_o}, 32'h1);
    drive_store(2'b11, 32'h0000_0700, 32'h9);
    tick();
    stop_store();
    sbif.fc_flush_mem_i = 1'b1;
    tick();
    tick();
    sbif.fc_flush_mem_i = 1'b0;
    chk("t6_flush_keeps_entry", {31'h0, sbif.sb_empty_o}, 32'h0);
    drain(32'h0000_0700, 1'b0, "t6_d1");
    chk("t6_drained", {31'h0, sbif.sb_empty_o}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
